// File: rtl/calculo_preco.sv
// Rounded price in cents of a weighed item: (peso_g * preco_kg + 500) / 1000.
// Sequential shift-add multiply, then restoring divide by 1000, fixed latency.
module calculo_preco #(
   parameter int W_PESO  = 12,
   parameter int W_PRECO = 10,
   parameter int W_CENT  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [W_PESO-1:0]  peso_g,
   input  logic [W_PRECO-1:0] preco_kg,
   output logic               busy,
   output logic               done,
   output logic [W_CENT-1:0]  centimos,
   output logic               overflow
);

   localparam int P  = W_PESO + W_PRECO;
   localparam int WC = $clog2(P + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MULT,
      S_ROUND,
      S_DIV,
      S_FIN
   } state_t;

   state_t              r_state;
   logic [P:0]          r_prod;
   logic [P-1:0]        r_mcand;
   logic [W_PESO-1:0]   r_mplier;
   logic [9:0]          r_rem;
   logic [WC-1:0]       r_cnt;

   logic [10:0]         w_trial;
   logic                w_qbit;
   logic [10:0]         w_rem_nxt;
   logic [P:0]          w_quot;
   logic                w_sat;

   // r_prod doubles as dividend shifter and quotient accumulator
   assign w_trial   = {r_rem, r_prod[P]};
   assign w_qbit    = (w_trial >= 11'd1000);
   assign w_rem_nxt = w_qbit ? (w_trial - 11'd1000) : w_trial;
   assign w_quot    = {r_prod[P-1:0], w_qbit};
   assign w_sat     = |w_quot[P:W_CENT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         centimos <= '0;
         overflow <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mcand  <= {{W_PESO{1'b0}}, preco_kg};
                  r_mplier <= peso_g;
                  r_prod   <= '0;
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  busy     <= 1'b1;
                  r_state  <= S_MULT;
               end
            end
            S_MULT: begin
               if (r_mplier[0])
                  r_prod <= r_prod + {1'b0, r_mcand};
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == WC'(W_PESO - 1)) begin
                  r_cnt   <= '0;
                  r_state <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_prod  <= r_prod + (P+1)'(500);
               r_state <= S_DIV;
            end
            S_DIV: begin
               r_prod <= w_quot;
               r_rem  <= w_rem_nxt[9:0];
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == WC'(P)) begin
                  r_state  <= S_FIN;
                  done     <= 1'b1;
                  overflow <= w_sat;
                  centimos <= w_sat ? '1 : w_quot[W_CENT-1:0];
               end
            end
            S_FIN: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calculo_preco.sv
// Randomized and directed checks of calculo_preco against an arithmetic model.
module tb_calculo_preco;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [11:0] peso_g;
   logic [9:0]  preco_kg;
   logic        busy;
   logic        done;
   logic [9:0]  centimos;
   logic        overflow;

   int n_vec;
   int n_err;

   calculo_preco dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .peso_g   (peso_g),
      .preco_kg (preco_kg),
      .busy     (busy),
      .done     (done),
      .centimos (centimos),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model_cent(input int p, input int k);
      int q;
      q = (p * k + 500) / 1000;
      return (q > 1023) ? 1023 : q;
   endfunction

   function automatic int model_ovf(input int p, input int k);
      return ((p * k + 500) / 1000 > 1023) ? 1 : 0;
   endfunction

   // one operation; inj=1 pulses start with other operands mid-run
   task automatic run_op(input int p, input int k, input bit inj,
                         input string tag);
      int lat;
      int ndone;
      bit seen;
      @(negedge clk);
      start    = 1'b1;
      peso_g   = 12'(p);
      preco_kg = 10'(k);
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      seen  = 1'b0;
      while (!seen && lat < 100) begin
         if (!busy) begin
            chk({tag, " busy_drop"}, lat, 37);
            lat = 100;
         end else if (done) begin
            seen = 1'b1;
         end else begin
            if (inj && (lat == 5 || lat == 20)) begin
               start    = 1'b1;
               peso_g   = 12'($urandom_range(1, 4095));
               preco_kg = 10'($urandom_range(1, 1023));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
         end
      end
      chk({tag, " latency"}, lat, 37);
      chk({tag, " centimos"}, int'(centimos), model_cent(p, k));
      chk({tag, " overflow"}, int'(overflow), model_ovf(p, k));
      ndone = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
         if (i == 0) chk({tag, " busy_after"}, int'(busy), 0);
      end
      chk({tag, " extra_done"}, ndone, 0);
   endtask

   initial begin
      int p;
      int k;
      int t0;
      int gap;
      bit ok;
      n_vec    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      peso_g   = '0;
      preco_kg = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst cent", int'(centimos), 0);
      chk("rst ovf", int'(overflow), 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1500, 100, 1'b0, "basic");
      run_op(125, 4, 1'b0, "half_up");
      run_op(100, 4, 1'b0, "below_half");
      run_op(333, 5, 1'b0, "r333_5");
      run_op(999, 1, 1'b0, "r999_1");
      run_op(4095, 1023, 1'b0, "max_sat");
      run_op(10, 10, 1'b0, "after_sat");
      run_op(0, 1023, 1'b0, "zero_peso");
      run_op(4095, 0, 1'b0, "zero_preco");
      run_op(777, 321, 1'b1, "start_busy");

      for (int i = 0; i < 25; i++) begin
         p = int'($urandom_range(0, 4095));
         k = int'($urandom_range(0, 1023));
         if (i % 5 == 0) p = int'($urandom_range(3000, 4095));
         run_op(p, k, 1'b0, "random");
      end

      // back-to-back with start held high
      @(negedge clk);
      start    = 1'b1;
      peso_g   = 12'd2000;
      preco_kg = 10'd250;
      t0 = -1;
      for (int n = 0; n < 3; n++) begin
         ok = 1'b0;
         for (int c = 0; c < 100 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (done) ok = 1'b1;
            if (t0 >= 0) t0++;
         end
         chk("b2b done_seen", int'(ok), 1);
         chk("b2b centimos", int'(centimos), 500);
         if (n > 0) chk("b2b period", t0, 38);
         t0  = 0;
         gap = 0;
         for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            t0++;
            if (!busy) gap++;
         end
         chk("b2b idle_gap", gap, 1);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (45) @(posedge clk);

      // reset during the divide phase
      @(negedge clk);
      start    = 1'b1;
      peso_g   = 12'd1234;
      preco_kg = 10'd567;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst busy", int'(busy), 0);
      chk("mid_rst cent", int'(centimos), 0);
      chk("mid_rst ovf", int'(overflow), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 45; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) ok = 1'b1;
      end
      chk("mid_rst no_done", int'(ok), 0);
      run_op(1500, 100, 1'b0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
